// File: rtl/ram_arb_if.sv
// ----------------------------------------------------------------------------
// ram_arb_if : one master's request/response bundle toward the RAM arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface ram_arb_if #(
   parameter int AW = 10,
   parameter int DW = 32
);
   logic          req;
   logic          we;
   logic [3:0]    be;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic          gnt;
   logic          rvalid;
   logic [DW-1:0] rdata;

   modport master (
      output req, we, be, addr, wdata,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, we, be, addr, wdata,
      output gnt, rvalid, rdata
   );
endinterface

`default_nettype wire

// File: rtl/ram_arb.sv
// ----------------------------------------------------------------------------
// ram_arb : two-master round-robin arbiter for a 1R1W RAM with byte-lane RMW
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ram_arb #(
   parameter int AW = 10,
   parameter int DW = 32
) (
   input  wire           clk,
   input  wire           rst_n,
   ram_arb_if.slave      m0,
   ram_arb_if.slave      m1,
   output logic          ram_we,
   output logic [AW-1:0] ram_waddr,
   output logic [DW-1:0] ram_wdata,
   output logic          ram_re,
   output logic [AW-1:0] ram_raddr,
   input  wire  [DW-1:0] ram_rdata,
   output logic          busy
);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      RMW_WR = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic          last_q, last_d;
   logic          rvalid0_q, rvalid0_d;
   logic          rvalid1_q, rvalid1_d;
   logic [AW-1:0] cap_addr_q, cap_addr_d;
   logic [DW-1:0] cap_wdata_q, cap_wdata_d;
   logic [3:0]    cap_be_q, cap_be_d;

   logic          sel;
   logic          gnt0, gnt1;
   logic          req_we;
   logic [3:0]    req_be;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      rvalid0_d   = 1'b0;
      rvalid1_d   = 1'b0;
      cap_addr_d  = cap_addr_q;
      cap_wdata_d = cap_wdata_q;
      cap_be_d    = cap_be_q;
      gnt0        = 1'b0;
      gnt1        = 1'b0;
      ram_we      = 1'b0;
      ram_waddr   = '0;
      ram_wdata   = '0;
      ram_re      = 1'b0;
      ram_raddr   = '0;

      // last_q=1 means m1 won most recently, so a tie then goes to m0
      sel       = (m0.req && m1.req) ? ~last_q : m1.req;
      req_we    = sel ? m1.we    : m0.we;
      req_be    = sel ? m1.be    : m0.be;
      req_addr  = sel ? m1.addr  : m0.addr;
      req_wdata = sel ? m1.wdata : m0.wdata;

      case (state_q)
         IDLE: begin
            if (m0.req || m1.req) begin
               gnt0   = ~sel;
               gnt1   = sel;
               last_d = sel;
               if (!req_we) begin
                  ram_re    = 1'b1;
                  ram_raddr = req_addr;
                  rvalid0_d = ~sel;
                  rvalid1_d = sel;
               end else if (req_be == 4'hF) begin
                  ram_we    = 1'b1;
                  ram_waddr = req_addr;
                  ram_wdata = req_wdata;
               end else if (req_be != 4'h0) begin
                  // Fetch the old word now; the merged word is written next cycle
                  ram_re      = 1'b1;
                  ram_raddr   = req_addr;
                  cap_addr_d  = req_addr;
                  cap_wdata_d = req_wdata;
                  cap_be_d    = req_be;
                  state_d     = RMW_WR;
               end
            end
         end
         RMW_WR: begin
            ram_we    = 1'b1;
            ram_waddr = cap_addr_q;
            for (int i = 0; i < 4; i++) begin
               ram_wdata[8*i +: 8] = cap_be_q[i] ? cap_wdata_q[8*i +: 8] : ram_rdata[8*i +: 8];
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         last_q      <= 1'b1;
         rvalid0_q   <= 1'b0;
         rvalid1_q   <= 1'b0;
         cap_addr_q  <= '0;
         cap_wdata_q <= '0;
         cap_be_q    <= '0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         rvalid0_q   <= rvalid0_d;
         rvalid1_q   <= rvalid1_d;
         cap_addr_q  <= cap_addr_d;
         cap_wdata_q <= cap_wdata_d;
         cap_be_q    <= cap_be_d;
      end
   end

   assign m0.gnt    = gnt0;
   assign m1.gnt    = gnt1;
   assign m0.rvalid = rvalid0_q;
   assign m1.rvalid = rvalid1_q;
   assign m0.rdata  = rvalid0_q ? ram_rdata : '0;
   assign m1.rdata  = rvalid1_q ? ram_rdata : '0;
   assign busy      = (state_q == RMW_WR);

endmodule

`default_nettype wire

// File: doc/ram_arb.md
RAM_ARB -- requirements
Module: ram_arb

Interface
REQ-001 Parameter AW, default 10, RAM word-address width.
REQ-002 Parameter DW, default 32, RAM data width; fixed at 32 (4 byte lanes).
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 mN_req  input  1  master N (N=0,1) access request; held until mN_gnt.
REQ-006 mN_we  input  1  1=write, 0=read.
REQ-007 mN_be  input  4  byte enables for writes; bit i selects bits [8i+7:8i]; ignored on reads.
REQ-008 mN_addr  input  AW  word address.
REQ-009 mN_wdata  input  DW  write data.
REQ-010 mN_gnt  output  1  combinational accept pulse; request consumed in this cycle.
REQ-011 mN_rvalid  output  1  read data valid for master N.
REQ-012 mN_rdata  output  DW  read data; equals ram_rdata when mN_rvalid=1, else 0.
REQ-013 ram_we / ram_waddr / ram_wdata  output  1/AW/DW  RAM write port.
REQ-014 ram_re / ram_raddr  output  1/AW  RAM read port.
REQ-015 ram_rdata  input  DW  RAM read data, valid the cycle after ram_re.
REQ-016 busy  output  1  high while in RMW_WR.

Function
REQ-017 States: IDLE, RMW_WR; at most one grant per cycle, only in IDLE.
REQ-018 Arbitration: round-robin; sole requester wins; if both request, the master not granted most recently wins; the last-granted pointer updates on every grant.
REQ-019 Read granted in cycle N: ram_re=1, ram_raddr=addr in N; mN_rvalid=1 in N+1 for the granted master only.
REQ-020 Write with be=4'hF granted in cycle N: ram_we=1, ram_waddr=addr, ram_wdata=wdata in N; state stays IDLE.
REQ-021 Write with be=4'h0: gnt pulses, no RAM access, no state change.
REQ-022 Partial write (be neither 0 nor F) granted in N: ram_re=1 at addr in N, addr/wdata/be captured, go to RMW_WR.
REQ-023 RMW_WR (cycle N+1): ram_we=1 at captured addr, ram_wdata = per-lane mux (be lane ? captured wdata : ram_rdata); no gnt, no rvalid; return to IDLE.
REQ-024 Requests pending during RMW_WR are held and arbitrated in N+2 with the pointer unchanged by the stall.
REQ-025 Back-to-back: read or full-write grant every cycle sustained; a read granted the cycle after a full write to the same address returns the new data.
REQ-026 Outputs not actively driven per REQ-019..023 are 0 (ram_we, ram_re, addresses, wdata, gnt).

Reset
REQ-027 rst_n=0 forces asynchronously: state IDLE, last-granted pointer = master 1 (master 0 wins first tie), mN_rvalid=0, busy=0, captured RMW regs 0.
REQ-028 Reset asserted in RMW_WR aborts the merge; no RAM write occurs.
REQ-029 Reset asserted the cycle after a read grant suppresses that rvalid.

Verification
REQ-030 Both request reads, addr 0x010 (m0) and 0x020 (m1), after reset -> m0_gnt cycle 0, m1_gnt cycle 1; m0_rvalid cycle 1, m1_rvalid cycle 2, data correct.
REQ-031 RAM word 0x005=0x11223344; m1 write be=4'b0101, wdata=0xAABBCCDD -> ram_re cycle 0, busy and ram_we cycle 1 with ram_wdata=0x11BB33DD; later read returns 0x11BB33DD.
REQ-032 m0 partial write while m1 requests read -> m1 not granted in RMW_WR, granted the following cycle.
REQ-033 m0 write be=4'hF 0xDEADBEEF to 0x3FF, next cycle m0 read 0x3FF -> rvalid with 0xDEADBEEF; be=0 write -> gnt only, RAM unchanged.
REQ-034 rst_n low during RMW_WR -> ram_we stays 0, target word unchanged, busy=0 immediately.
REQ-035 Continuous requests from both masters for 100 cycles -> grants strictly alternate, no cycle with both gnt high.
